// File: rtl/seq_result_collector.sv
// Result collector behind the 0-6-4-2 sequence detector: captures {detect, sum} on each
// done rising edge into a small FIFO, drains it via valid/ready, and keeps status counters.
module seq_result_collector #(
  parameter int         DEPTH   = 4,
  parameter int         CNT_W   = 8,
  parameter logic [3:0] EXP_SUM = 4'd12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     done_i,
  input  logic [3:0]               sum_i,
  input  logic [1:0]               detect_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     overflow,
  output logic                     sum_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [5:0]       mem_r [DEPTH];
  logic             done_q_r;
  logic [CNT_W-1:0] match_cnt_r;
  logic             overflow_r;
  logic             sum_err_r;

  logic             empty_s;
  logic             full_s;
  logic             cap_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             match_s;
  logic             bad_sum_s;

  // Wrap-bit pointers: equal means empty, differing only in the wrap bit means full.
  assign empty_s   = (rd_ptr_r == wr_ptr_r);
  assign full_s    = (rd_ptr_r[AW] != wr_ptr_r[AW]) &&
                     (rd_ptr_r[AW-1:0] == wr_ptr_r[AW-1:0]);
  assign cap_s     = done_i & ~done_q_r;
  assign pop_s     = ~empty_s & out_ready;
  assign push_s    = cap_s & (~full_s | pop_s);
  assign drop_s    = cap_s & full_s & ~pop_s;
  assign match_s   = cap_s & (detect_i == 2'd1);
  assign bad_sum_s = cap_s & (sum_i != EXP_SUM);

  // Every output is a decode of registered state only.
  assign out_valid = ~empty_s;
  assign empty     = empty_s;
  assign full      = full_s;
  assign level     = wr_ptr_r - rd_ptr_r;
  assign out_data  = mem_r[rd_ptr_r[AW-1:0]];
  assign match_cnt = match_cnt_r;
  assign overflow  = overflow_r;
  assign sum_err   = sum_err_r;

  // FIFO pointers and edge-detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      done_q_r <= 1'b0;
    end else if (clear) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      done_q_r <= 1'b0;
    end else begin
      done_q_r <= done_i;
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage; cleared so an idle head reads as zero after reset or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 6'd0;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 6'd0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {detect_i, sum_i};
    end
  end

  // Status: saturating match count and sticky flags, which also see dropped captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt_r <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      sum_err_r   <= 1'b0;
    end else if (clear) begin
      match_cnt_r <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      sum_err_r   <= 1'b0;
    end else begin
      if (match_s && (match_cnt_r != CNT_MAX)) begin
        match_cnt_r <= match_cnt_r + CNT_ONE;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (bad_sum_s) begin
        sum_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_result_collector.sv
// Bench for seq_result_collector: queue-based reference model with a per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seq_result_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       done_i = 1'b0;
  logic [3:0] sum_i = 4'd0;
  logic [1:0] detect_i = 2'd0;
  logic       out_ready = 1'b0;

  logic       out_valid, empty, full, overflow, sum_err;
  logic [5:0] out_data;
  logic [2:0] level;
  logic [7:0] match_cnt;

  logic       s_out_valid, s_empty, s_full, s_overflow, s_sum_err;
  logic [5:0] s_out_data;
  logic [2:0] s_level;
  logic [1:0] s_match_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // reference model state
  int m_q[$];
  bit m_done_q = 1'b0;
  int m_cnt = 0;
  int m_cnt_small = 0;
  bit m_ovf = 1'b0;
  bit m_serr = 1'b0;

  seq_result_collector #(.DEPTH(4), .CNT_W(8), .EXP_SUM(4'd12)) dut (
    .clk(clk), .rst(rst), .clear(clear), .done_i(done_i), .sum_i(sum_i),
    .detect_i(detect_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .empty(empty), .full(full), .level(level),
    .match_cnt(match_cnt), .overflow(overflow), .sum_err(sum_err)
  );

  seq_result_collector #(.DEPTH(4), .CNT_W(2), .EXP_SUM(4'd12)) dut_small (
    .clk(clk), .rst(rst), .clear(clear), .done_i(done_i), .sum_i(sum_i),
    .detect_i(detect_i), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .empty(s_empty), .full(s_full), .level(s_level),
    .match_cnt(s_match_cnt), .overflow(s_overflow), .sum_err(s_sum_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_done_q = 1'b0;
    m_cnt = 0;
    m_cnt_small = 0;
    m_ovf = 1'b0;
    m_serr = 1'b0;
  endtask

  // Model: one result captured per done rising edge, FIFO of at most 4, pop frees a slot first.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else if (clear) begin
        model_reset();
      end else begin
        bit cap, pop;
        cap = done_i && !m_done_q;
        pop = (m_q.size() != 0) && out_ready;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
          if (m_q.size() < 4) m_q.push_back({detect_i, sum_i});
          else m_ovf = 1'b1;
          if (detect_i == 2'd1) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_small < 3) m_cnt_small++;
          end
          if (sum_i != 4'd12) m_serr = 1'b1;
        end
        m_done_q = done_i;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("empty", empty, m_q.size() == 0);
        chk("full", full, m_q.size() == 4);
        chk("level", level, m_q.size());
        if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
        chk("match_cnt", match_cnt, m_cnt);
        chk("match_cnt_small", s_match_cnt, m_cnt_small);
        chk("overflow", overflow, m_ovf);
        chk("sum_err", sum_err, m_serr);
        chk("level_small", s_level, m_q.size());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] s, input logic [1:0] d);
    done_i = 1'b1; sum_i = s; detect_i = d;
    cyc();
    done_i = 1'b0;
    cyc();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    cyc();

    // reset mid-run with three entries buffered
    repeat (3) pulse(4'd12, 2'd1);
    @(negedge clk); chk("t1_level_before", level, 3);
    rst = 1'b1;
    #1;
    chk("t1_empty", empty, 1); chk("t1_level", level, 0);
    chk("t1_valid", out_valid, 0); chk("t1_cnt", match_cnt, 0);
    chk("t1_ovf", overflow, 0); chk("t1_serr", sum_err, 0);
    chk("t1_data", out_data, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // single result, latency of one edge
    done_i = 1'b1; sum_i = 4'd12; detect_i = 2'd1;
    cyc();
    done_i = 1'b0;
    @(negedge clk);
    chk("t2_valid", out_valid, 1); chk("t2_data", out_data, 6'b01_1100);
    chk("t2_level", level, 1); chk("t2_cnt", match_cnt, 1); chk("t2_serr", sum_err, 0);
    cyc();
    do_clear();

    // done held 5 cycles gives one capture
    done_i = 1'b1; sum_i = 4'd12; detect_i = 2'd1;
    repeat (5) cyc();
    done_i = 1'b0;
    cyc();
    @(negedge clk); chk("t3_level", level, 1); chk("t3_cnt", match_cnt, 1);
    cyc();
    do_clear();

    // fill, overflow, drain
    repeat (4) pulse(4'd12, 2'd1);
    pulse(4'd3, 2'd1);
    @(negedge clk);
    chk("t4_full", full, 1); chk("t4_level", level, 4); chk("t4_ovf", overflow, 1);
    chk("t4_serr", sum_err, 1); chk("t4_cnt", match_cnt, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t4_drain", out_data, 6'h1C);
      cyc();
    end
    out_ready = 1'b0;
    @(negedge clk); chk("t4_empty", empty, 1);
    cyc();
    do_clear();

    // full with simultaneous pop and capture
    repeat (4) pulse(4'd12, 2'd0);
    @(negedge clk); chk("t5_full_before", full, 1);
    done_i = 1'b1; sum_i = 4'd12; detect_i = 2'd2; out_ready = 1'b1;
    cyc();
    done_i = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t5_level", level, 4); chk("t5_ovf", overflow, 0);
    cyc();
    do_clear();

    // saturation of the narrow counter, then clear beating a done edge
    repeat (5) pulse(4'd12, 2'd1);
    @(negedge clk); chk("t6_sat", s_match_cnt, 3); chk("t6_cnt8", match_cnt, 5);
    clear = 1'b1; done_i = 1'b1; sum_i = 4'd3; detect_i = 2'd1;
    cyc();
    clear = 1'b0; done_i = 1'b0;
    @(negedge clk);
    chk("t6_level", level, 0); chk("t6_cnt", match_cnt, 0); chk("t6_small", s_match_cnt, 0);
    chk("t6_serr", sum_err, 0); chk("t6_ovf", overflow, 0); chk("t6_empty", empty, 1);
    cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      done_i    = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      sum_i     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd12;
      detect_i  = 2'($urandom_range(0, 3));
      clear     = ($urandom_range(0, 199) == 0);
      cyc();
    end
    clear = 1'b0; done_i = 1'b0; out_ready = 1'b0;
    cyc();
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
